// File: rtl/pipeline_processor.sv
// Four-stage (IF/ID/EX/WB) in-order 16-bit-instruction core with its own ROMs and full forwarding.
// Define HALT_EN to make opcode 15 a HALT that freezes fetch; otherwise opcode 15 is a NOP.
module pipeline_processor #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned IMEM_DEPTH = 64,
    parameter int unsigned DMEM_DEPTH = 64,
    parameter string       IMEM_FILE  = "imem.hex",
    parameter string       DMEM_FILE  = "dmem.hex",
    localparam int unsigned PC_W      = $clog2(IMEM_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    output logic [PC_W-1:0]   pc_o,
    output logic              wb_valid,
    output logic [2:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              halted
);

    localparam int unsigned DA_W = $clog2(DMEM_DEPTH);

    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_ADDI = 4'd5;
    localparam logic [3:0] OP_LOAD = 4'd6;

    logic [15:0]       imem [IMEM_DEPTH];
    logic [DATA_W-1:0] dmem [DMEM_DEPTH];

    // ROM contents default to zero (NOP / data 0).
    initial begin
        for (int i = 0; i < int'(IMEM_DEPTH); i++) imem[i] = '0;
        for (int i = 0; i < int'(DMEM_DEPTH); i++) dmem[i] = '0;
    end

    // Pipeline state
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [15:0]       ifid_instr_q, ifid_instr_d;
    logic              ifid_valid_q, ifid_valid_d;

    logic [3:0]        idex_op_q;
    logic [2:0]        idex_rd_q, idex_rs1_q, idex_rs2_q;
    logic [DATA_W-1:0] idex_a_q, idex_b_q, idex_imm_q;
    logic              idex_valid_q;

    logic              exwb_valid_q;
    logic [2:0]        exwb_rd_q;
    logic [DATA_W-1:0] exwb_data_q;

    logic [DATA_W-1:0] rf_q [8];

    // IF
    logic [PC_W-1:0] pc_inc;

    always_comb begin
        pc_inc = (pc_q == PC_W'(IMEM_DEPTH - 1)) ? '0 : pc_q + PC_W'(1);
    end

    // ID
    logic [3:0]        id_op;
    logic [2:0]        id_rd, id_rs1, id_rs2;
    logic [DATA_W-1:0] id_imm, id_a, id_b;
    logic              id_writes;

    always_comb begin
        id_op     = ifid_instr_q[15:12];
        id_rd     = ifid_instr_q[11:9];
        id_rs1    = ifid_instr_q[8:6];
        id_rs2    = ifid_instr_q[5:3];
        id_imm    = DATA_W'(ifid_instr_q[5:0]);
        id_writes = ifid_valid_q && (id_rd != 3'd0) &&
                    (id_op >= OP_ADD) && (id_op <= OP_LOAD);

        // Register read with write-through from the WB stage
        if (id_rs1 == 3'd0) begin
            id_a = '0;
        end else if (exwb_valid_q && (exwb_rd_q == id_rs1)) begin
            id_a = exwb_data_q;
        end else begin
            id_a = rf_q[id_rs1];
        end

        if (id_rs2 == 3'd0) begin
            id_b = '0;
        end else if (exwb_valid_q && (exwb_rd_q == id_rs2)) begin
            id_b = exwb_data_q;
        end else begin
            id_b = rf_q[id_rs2];
        end
    end

    // EX
    logic [DATA_W-1:0] ex_a, ex_b, ex_ea, ex_result;
    logic [DA_W-1:0]   ex_daddr;

    always_comb begin
        ex_a = idex_a_q;
        ex_b = idex_b_q;
        if (exwb_valid_q && (idex_rs1_q != 3'd0) && (exwb_rd_q == idex_rs1_q)) begin
            ex_a = exwb_data_q;
        end
        if (exwb_valid_q && (idex_rs2_q != 3'd0) && (exwb_rd_q == idex_rs2_q)) begin
            ex_b = exwb_data_q;
        end

        ex_ea    = ex_a + idex_imm_q;
        ex_daddr = DA_W'(32'(ex_ea) % DMEM_DEPTH);

        case (idex_op_q)
            OP_ADD:  ex_result = ex_a + ex_b;
            OP_SUB:  ex_result = ex_a - ex_b;
            OP_AND:  ex_result = ex_a & ex_b;
            OP_OR:   ex_result = ex_a | ex_b;
            OP_ADDI: ex_result = ex_ea;
            OP_LOAD: ex_result = dmem[ex_daddr];
            default: ex_result = '0;
        endcase
    end

    // Fetch control, with optional halt
`ifdef HALT_EN
    logic halted_q, halted_d;
    logic halt_now;

    always_comb begin
        halt_now = ifid_valid_q && (id_op == 4'hF) && !halted_q;
        halted_d = halted_q | halt_now;
        // The word fetched alongside the HALT is squashed; fetch stops afterwards.
        pc_d         = halted_q ? pc_q : pc_inc;
        ifid_instr_d = (halted_q || halt_now) ? 16'h0000 : imem[pc_q];
        ifid_valid_d = !(halted_q || halt_now);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    assign halted = halted_q;
`else
    always_comb begin
        pc_d         = pc_inc;
        ifid_instr_d = imem[pc_q];
        ifid_valid_d = 1'b1;
    end

    assign halted = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q         <= '0;
            ifid_instr_q <= '0;
            ifid_valid_q <= 1'b0;
            idex_op_q    <= '0;
            idex_rd_q    <= '0;
            idex_rs1_q   <= '0;
            idex_rs2_q   <= '0;
            idex_a_q     <= '0;
            idex_b_q     <= '0;
            idex_imm_q   <= '0;
            idex_valid_q <= 1'b0;
            exwb_valid_q <= 1'b0;
            exwb_rd_q    <= '0;
            exwb_data_q  <= '0;
            for (int i = 0; i < 8; i++) rf_q[i] <= '0;
        end else begin
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;

            idex_op_q    <= id_writes ? id_op : 4'd0;
            idex_rd_q    <= id_rd;
            idex_rs1_q   <= id_rs1;
            idex_rs2_q   <= id_rs2;
            idex_a_q     <= id_a;
            idex_b_q     <= id_b;
            idex_imm_q   <= id_imm;
            idex_valid_q <= id_writes;

            exwb_valid_q <= idex_valid_q;
            exwb_rd_q    <= idex_rd_q;
            exwb_data_q  <= ex_result;

            if (exwb_valid_q) rf_q[exwb_rd_q] <= exwb_data_q;
        end
    end

    assign pc_o     = pc_q;
    assign wb_valid = exwb_valid_q;
    assign wb_rd    = exwb_rd_q;
    assign wb_data  = exwb_data_q;

endmodule

// File: tb/tb_pipeline_processor.sv
// Self-checking bench for pipeline_processor: random programs against an architectural model,
// a hand-derived vector table, PC wrap, mid-run reset and (with HALT_EN) the halt sequence.
module tb_pipeline_processor;

    logic       clk;
    logic       reset;
    logic [5:0] pc_o;
    logic       wb_valid;
    logic [2:0] wb_rd;
    logic [7:0] wb_data;
    logic       halted;

    pipeline_processor #(
        .DATA_W     (8),
        .IMEM_DEPTH (64),
        .DMEM_DEPTH (64),
        .IMEM_FILE  (""),
        .DMEM_FILE  ("")
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pc_o     (pc_o),
        .wb_valid (wb_valid),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .halted   (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int edge_cnt = 0;

    logic [15:0] m_imem [64];
    int          m_dmem [64];
    int          m_rf   [8];

    typedef struct {
        logic [15:0] instr;
        bit          v;
        int          rd;
        int          data;
    } vec_t;

    vec_t tbl [18];

    function automatic logic [15:0] enc(input int op, input int rd, input int rs1, input int f);
        logic [3:0] o;
        logic [2:0] d;
        logic [2:0] s;
        logic [5:0] ff;
        o  = 4'(op);
        d  = 3'(rd);
        s  = 3'(rs1);
        ff = 6'(f);
        return {o, d, s, ff};
    endfunction

    function automatic int rr(input int r);
        return r * 8;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural execution of one instruction, in program order.
    task automatic model_exec(input logic [15:0] ins, output bit we, output int rd, output int val);
        int op, rs1, rs2, imm, a, b;
        op  = int'(ins[15:12]);
        rd  = int'(ins[11:9]);
        rs1 = int'(ins[8:6]);
        rs2 = int'(ins[5:3]);
        imm = int'(ins[5:0]);
        a   = (rs1 == 0) ? 0 : m_rf[rs1];
        b   = (rs2 == 0) ? 0 : m_rf[rs2];
        case (op)
            1:       val = (a + b) % 256;
            2:       val = (a - b + 256) % 256;
            3:       val = a & b;
            4:       val = a | b;
            5:       val = (a + imm) % 256;
            6:       val = m_dmem[((a + imm) % 256) % 64];
            default: val = 0;
        endcase
        we = (op >= 1) && (op <= 6) && (rd != 0);
        if (we) m_rf[rd] = val;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_mem();
        for (int i = 0; i < 64; i++) begin
            dut.imem[i] = m_imem[i];
            dut.dmem[i] = 8'(m_dmem[i]);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) m_rf[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset pc", int'(pc_o), 0);
        chk("reset wb_valid", int'(wb_valid), 0);
        chk("reset wb_rd", int'(wb_rd), 0);
        chk("reset wb_data", int'(wb_data), 0);
        chk("reset halted", int'(halted), 0);
        reset    = 1'b1;
        edge_cnt = 0;
    endtask

    // One clock, then compare pc and the WB stage against the model.
    task automatic step_check(input string tag);
        bit we;
        int rd, val;
        tick();
        edge_cnt++;
        chk({tag, " pc"}, int'(pc_o), edge_cnt % 64);
        if (edge_cnt < 3) begin
            chk({tag, " early wb_valid"}, int'(wb_valid), 0);
        end else begin
            model_exec(m_imem[(edge_cnt - 3) % 64], we, rd, val);
            chk({tag, " wb_valid"}, int'(wb_valid), int'(we));
            if (we) begin
                chk({tag, " wb_rd"}, int'(wb_rd), rd);
                chk({tag, " wb_data"}, int'(wb_data), val);
            end
        end
    endtask

    task automatic run_table(input string tag);
        step_check(tag);
        step_check(tag);
        for (int k = 0; k < 18; k++) begin
            step_check(tag);
            chk($sformatf("%s tbl[%0d] valid", tag, k), int'(wb_valid), int'(tbl[k].v));
            if (tbl[k].v) begin
                chk($sformatf("%s tbl[%0d] rd", tag, k), int'(wb_rd), tbl[k].rd);
                chk($sformatf("%s tbl[%0d] data", tag, k), int'(wb_data), tbl[k].data);
            end
        end
    endtask

    initial begin
        int op_max;
        reset = 1'b0;
        #1;

        tbl[0]  = '{enc(6, 1, 0, 0),      1'b1, 1, 5};
        tbl[1]  = '{enc(6, 2, 0, 1),      1'b1, 2, 3};
        tbl[2]  = '{enc(1, 3, 1, rr(2)),  1'b1, 3, 8};
        tbl[3]  = '{enc(2, 4, 3, rr(1)),  1'b1, 4, 3};
        tbl[4]  = '{enc(3, 5, 3, rr(2)),  1'b1, 5, 0};
        tbl[5]  = '{enc(4, 6, 3, rr(2)),  1'b1, 6, 11};
        tbl[6]  = '{enc(5, 7, 6, 63),     1'b1, 7, 74};
        tbl[7]  = '{enc(5, 1, 0, 63),     1'b1, 1, 63};
        tbl[8]  = '{enc(1, 1, 1, rr(1)),  1'b1, 1, 126};
        tbl[9]  = '{enc(1, 1, 1, rr(1)),  1'b1, 1, 252};
        tbl[10] = '{enc(1, 1, 1, rr(1)),  1'b1, 1, 248};
        tbl[11] = '{enc(5, 0, 0, 9),      1'b0, 0, 0};
        tbl[12] = '{enc(1, 2, 0, rr(0)),  1'b1, 2, 0};
        tbl[13] = '{enc(2, 3, 0, rr(6)),  1'b1, 3, 245};
        tbl[14] = '{enc(6, 4, 7, 54),     1'b1, 4, 5};
        tbl[15] = '{enc(1, 5, 4, rr(4)),  1'b1, 5, 10};
        tbl[16] = '{enc(9, 3, 1, rr(2)),  1'b0, 0, 0};
        tbl[17] = '{enc(7, 6, 2, 5),      1'b0, 0, 0};

`ifdef HALT_EN
        op_max = 14;
`else
        op_max = 15;
`endif

        // Random program and data, checked against the model across two PC wraps
        for (int i = 0; i < 64; i++) begin
            m_imem[i] = 16'($urandom);
            m_imem[i][15:12] = 4'($urandom_range(0, op_max));
            m_dmem[i] = int'($urandom_range(0, 255));
        end
        load_mem();
        apply_reset();
        for (int i = 0; i < 150; i++) step_check("rand");

        // Reset from arbitrary state, then PC counts 1, 2, 3
        apply_reset();
        for (int i = 0; i < 3; i++) step_check("post-reset");

        // Directed program from the table
        for (int i = 0; i < 64; i++) begin
            m_imem[i] = (i < 18) ? tbl[i].instr : 16'h0000;
            m_dmem[i] = 0;
        end
        m_dmem[0] = 5;
        m_dmem[1] = 3;
        load_mem();
        apply_reset();
        run_table("table");
        while (edge_cnt < 90) begin
            step_check("wrap");
            if (edge_cnt == 63) chk("pc at 63", int'(pc_o), 63);
            if (edge_cnt == 64) chk("pc wrapped", int'(pc_o), 0);
        end

        // Asynchronous reset in the middle of the LOAD-use sequence
        apply_reset();
        for (int i = 0; i < 4; i++) step_check("pre-midrst");
        #3;
        reset = 1'b0;
        #1;
        chk("midrst wb_valid", int'(wb_valid), 0);
        chk("midrst pc", int'(pc_o), 0);
        apply_reset();
        run_table("rerun");

`ifdef HALT_EN
        for (int i = 0; i < 64; i++) m_imem[i] = 16'h0000;
        m_imem[0] = enc(5, 1, 0, 1);
        m_imem[1] = 16'hF000;
        m_imem[2] = enc(5, 2, 0, 2);
        load_mem();
        apply_reset();
        tick();
        chk("halt e1 halted", int'(halted), 0);
        tick();
        chk("halt e2 halted", int'(halted), 0);
        tick();
        chk("halt e3 wb_valid", int'(wb_valid), 1);
        chk("halt e3 wb_rd", int'(wb_rd), 1);
        chk("halt e3 wb_data", int'(wb_data), 1);
        chk("halt e3 halted", int'(halted), 1);
        chk("halt e3 pc", int'(pc_o), 3);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("halt halted", int'(halted), 1);
            chk("halt pc frozen", int'(pc_o), 3);
            chk("halt r2 write", int'(wb_valid && (wb_rd == 3'd2)), 0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
